// File: rtl/heater_pkg.sv
`default_nettype none
// ==========================================================================
// heater_pkg: LFSR step / seed helpers and checker state type for the heater array.  Rev 1.0
// ==========================================================================
package heater_pkg;

  typedef enum logic {SYNC = 1'b0, CHECK = 1'b1} chk_state_t;

  function automatic logic [63:0] width_mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Galois (right-shift) feedback masks; bit w-1 is always set so the step is invertible
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_A300_0000;
      48:      return 64'h0000_C000_0018_0000;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h3 << (w - 2);
    endcase
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] x, input int w);
    logic [63:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ lfsr_taps(w);
    return y & width_mask(w);
  endfunction

  function automatic logic [63:0] ch_seed(input logic [63:0] seed, input int ch, input int w);
    logic [63:0] s;
    s = (seed + 64'(ch) * 64'h9E37_79B9_7F4A_7C15) & width_mask(w);
    return (s == 64'd0) ? 64'd1 : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heater_channel.sv
`default_nettype none
// ==========================================================================
// heater_channel: LFSR generator -> register pipe -> self-synchronising checker.
// Optional HEATER_INJECT_EN adds a one-shot bit-0 flip input.  Rev 1.0
// ==========================================================================
module heater_channel
  import heater_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          PIPE_DEPTH = 16,
  parameter int          SYNC_CNT   = 4,
  parameter int          MISS_MAX   = 8,
  parameter int          CNT_W      = 16,
  parameter logic [63:0] SEED       = 64'hACE1,
  parameter int          CH         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             err_clear,
`ifdef HEATER_INJECT_EN
  input  logic             inject,
`endif
  output logic             error,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(SYNC_CNT + 1);
  localparam int MISS_W  = $clog2(MISS_MAX + 1);
  localparam logic [DATA_W-1:0]  SEED_W     = DATA_W'(ch_seed(SEED, CH, DATA_W));
  localparam logic [MATCH_W-1:0] SYNC_LAST  = MATCH_W'(SYNC_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_MAX - 1);

  logic [DATA_W-1:0] gen_q;
  logic              gen_v;
  logic [DATA_W-1:0] pipe_in;
  logic [DATA_W-1:0] pipe_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] pipe_v;
  logic [DATA_W-1:0] chk_data;
  logic              chk_valid;

  // Generator holds its data while disabled so an idle channel does not toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_q <= SEED_W;
      gen_v <= 1'b0;
    end else if (en) begin
      gen_q <= DATA_W'(lfsr_next(64'(gen_q), DATA_W));
      gen_v <= 1'b1;
    end else begin
      gen_v <= 1'b0;
    end
  end

`ifdef HEATER_INJECT_EN
  logic inj_q, inj_arm, gen_flip, inj_pend;
  assign inj_pend = inj_arm | (inject & ~inj_q);
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_q    <= 1'b0;
      inj_arm  <= 1'b0;
      gen_flip <= 1'b0;
    end else begin
      inj_q    <= inject;
      inj_arm  <= inj_pend & ~en;
      gen_flip <= inj_pend & en;
    end
  end
  assign pipe_in = {gen_q[DATA_W-1:1], gen_q[0] ^ gen_flip};
`else
  assign pipe_in = gen_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_d[i] <= '0;
        pipe_v[i] <= 1'b0;
      end
    end else begin
      pipe_d[0] <= pipe_in;
      pipe_v[0] <= gen_v;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  assign chk_data  = pipe_d[PIPE_DEPTH-1];
  assign chk_valid = pipe_v[PIPE_DEPTH-1];

  chk_state_t         state_q, state_n;
  logic [MATCH_W-1:0] match_q, match_n;
  logic [MISS_W-1:0]  miss_q, miss_n;
  logic [DATA_W-1:0]  prev_q, prev_n, exp_word;
  logic               prev_v_q, prev_v_n;
  logic               error_q, error_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               good;

  // Zero is the LFSR lock-up value and can never be a legitimate word
  assign exp_word = DATA_W'(lfsr_next(64'(prev_q), DATA_W));
  assign good     = chk_valid && prev_v_q && (chk_data != '0) && (chk_data == exp_word);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SYNC;
      match_q  <= '0;
      miss_q   <= '0;
      prev_q   <= '0;
      prev_v_q <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_n;
      match_q  <= match_n;
      miss_q   <= miss_n;
      prev_q   <= prev_n;
      prev_v_q <= prev_v_n;
      error_q  <= error_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    match_n  = match_q;
    miss_n   = miss_q;
    prev_n   = prev_q;
    prev_v_n = prev_v_q;
    error_n  = error_q;
    cnt_n    = cnt_q;
    if (chk_valid) begin
      prev_n   = chk_data;
      prev_v_n = 1'b1;
    end
    case (state_q)
      SYNC: begin
        if (chk_valid) begin
          if (!good) begin
            match_n = '0;
          end else if (match_q == SYNC_LAST) begin
            state_n = CHECK;
            match_n = '0;
            miss_n  = '0;
          end else begin
            match_n = match_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (chk_valid) begin
          if (good) begin
            miss_n = '0;
          end else begin
            error_n = 1'b1;
            cnt_n   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (miss_q == MISS_LAST) begin
              state_n = SYNC;
              miss_n  = '0;
              match_n = '0;
            end else begin
              miss_n = miss_q + 1'b1;
            end
          end
        end
      end
      default: state_n = SYNC;
    endcase
    if (err_clear) begin
      error_n = 1'b0;
      cnt_n   = '0;
      miss_n  = '0;
      match_n = '0;
      state_n = SYNC;
    end
  end

  assign error     = error_q;
  assign locked    = (state_q == CHECK);
  assign err_count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/heater_array.sv
`default_nettype none
// ==========================================================================
// heater_array: NUM_CH independent heater channels plus a registered any_error.
// Optional HEATER_INJECT_EN exposes the per-channel inject port.  Rev 1.0
// ==========================================================================
module heater_array
  import heater_pkg::*;
#(
  parameter int          NUM_CH     = 8,
  parameter int          DATA_W     = 32,
  parameter int          PIPE_DEPTH = 16,
  parameter int          SYNC_CNT   = 4,
  parameter int          MISS_MAX   = 8,
  parameter int          CNT_W      = 16,
  parameter logic [63:0] SEED       = 64'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    err_clear,
`ifdef HEATER_INJECT_EN
  input  logic [NUM_CH-1:0]       inject,
`endif
  output logic [NUM_CH-1:0]       error,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH*CNT_W-1:0] err_count,
  output logic                    any_error
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    heater_channel #(
      .DATA_W    (DATA_W),
      .PIPE_DEPTH(PIPE_DEPTH),
      .SYNC_CNT  (SYNC_CNT),
      .MISS_MAX  (MISS_MAX),
      .CNT_W     (CNT_W),
      .SEED      (SEED),
      .CH        (c)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (ch_en[c]),
      .err_clear(err_clear),
`ifdef HEATER_INJECT_EN
      .inject   (inject[c]),
`endif
      .error    (error[c]),
      .locked   (locked[c]),
      .err_count(err_count[c*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) any_error <= 1'b0;
    else       any_error <= |error;
  end

endmodule
`default_nettype wire
